csr_master_bridge: RTL and testbench

- Initiator end of the DMA CSR bus: turns single command requests from a host-side sequencer or test controller into CSR read/write transfers on the wait-request CSR interface of the DMA register block.
- Holds each transfer until the responder drops wait-request, captures read data, and returns one response per command.
- Optional timeout converts a hung transfer into an error response.

---
 rtl/csr_master_bridge.sv | 148 ++++++++++++++
 tb/tb_csr_master_bridge.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/csr_master_bridge.sv
// csr_master_bridge: issues one CSR transfer per host command and returns one response.
// A transfer is held until the responder drops wait-request. Read data is captured at
// the accepting edge or one cycle later, depending on RDATA_DELAY. An optional timeout
// turns a transfer that stays stalled into an error response.
module csr_master_bridge #(
    parameter int ADDR_W         = 4,
    parameter int DATA_W         = 32,
    parameter int RDATA_DELAY    = 1,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic                cmd_write_i,
    input  logic [ADDR_W-1:0]   cmd_addr_i,
    input  logic [DATA_W-1:0]   cmd_wdata_i,
    input  logic [DATA_W/8-1:0] cmd_be_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [DATA_W-1:0]   rsp_rdata_o,
    output logic                rsp_write_o,
    output logic                rsp_error_o,
    output logic                csr_wr_o,
    output logic                csr_rd_o,
    output logic [ADDR_W-1:0]   csr_addr_o,
    output logic [DATA_W-1:0]   csr_wr_data_o,
    output logic [DATA_W/8-1:0] csr_be_o,
    input  logic                csr_wait_rq_i,
    input  logic [DATA_W-1:0]   csr_rd_data_i,
    output logic [1:0]          dbg_state
);

    // Handshakes: a command moves on an edge where cmd_valid_i & cmd_ready_o, a
    // response on an edge where rsp_valid_o & rsp_ready_i; a CSR transfer completes
    // on an edge where a strobe is high and csr_wait_rq_i is low. Valid and payload
    // stay stable until the matching handshake.

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int LAST  = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAST);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam bit TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam bit RD_LATE = (RDATA_DELAY != 0);

    typedef enum logic [1:0] {IDLE, REQ, RD_CAP, RESP} state_t;

    state_t            state, state_d;
    logic              wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [BE_W-1:0]   be_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              error_q, error_d;
    logic              load;

    // Next-state, counter and response-capture decisions.
    always_comb begin
        state_d = state;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        error_d = error_q;
        load    = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid_i) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    rdata_d = '0;
                    error_d = 1'b0;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (!csr_wait_rq_i) begin
                    // Acceptance wins over a timeout on the same edge.
                    if (wr_q) begin
                        state_d = RESP;
                    end else if (!RD_LATE) begin
                        rdata_d = csr_rd_data_i;
                        state_d = RESP;
                    end else begin
                        state_d = RD_CAP;
                    end
                end else begin
                    if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
                    if (TO_EN && (cnt_q == CNT_LAST)) begin
                        error_d = 1'b1;
                        rdata_d = '0;
                        state_d = RESP;
                    end
                end
            end
            RD_CAP: begin
                rdata_d = csr_rd_data_i;
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, command latch and response registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            error_q <= 1'b0;
        end else begin
            state   <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            error_q <= error_d;
            if (load) begin
                wr_q    <= cmd_write_i;
                addr_q  <= cmd_addr_i;
                wdata_q <= cmd_wdata_i;
                be_q    <= cmd_be_i;
            end
        end
    end

    // Outputs are decoded from state so strobes can only be high in REQ and the
    // response fields only show in RESP.
    always_comb begin
        cmd_ready_o   = (state == IDLE);
        csr_wr_o      = (state == REQ) &  wr_q;
        csr_rd_o      = (state == REQ) & ~wr_q;
        csr_addr_o    = (state == REQ) ? addr_q  : '0;
        csr_wr_data_o = (state == REQ) ? wdata_q : '0;
        csr_be_o      = (state == REQ) ? be_q    : '0;
        rsp_valid_o   = (state == RESP);
        rsp_rdata_o   = (state == RESP) ? rdata_q : '0;
        rsp_write_o   = (state == RESP) & wr_q;
        rsp_error_o   = (state == RESP) & error_q;
        dbg_state     = state;
    end

endmodule

// File: tb/tb_csr_master_bridge.sv
// Directed bench for csr_master_bridge with default parameters
// (RDATA_DELAY=1, TIMEOUT_CYCLES=16).
module tb_csr_master_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid_i, cmd_ready_o, cmd_write_i;
  logic [3:0]  cmd_addr_i;
  logic [31:0] cmd_wdata_i;
  logic [3:0]  cmd_be_i;
  logic        rsp_valid_o, rsp_ready_i, rsp_write_o, rsp_error_o;
  logic [31:0] rsp_rdata_o;
  logic        csr_wr_o, csr_rd_o;
  logic [3:0]  csr_addr_o;
  logic [31:0] csr_wr_data_o;
  logic [3:0]  csr_be_o;
  logic        csr_wait_rq_i;
  logic [31:0] csr_rd_data_i;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] JUNK = 32'hA5A5_A5A5;

  csr_master_bridge dut (
    .clk(clk), .reset(reset),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
    .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i), .cmd_be_i(cmd_be_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .rsp_write_o(rsp_write_o), .rsp_error_o(rsp_error_o),
    .csr_wr_o(csr_wr_o), .csr_rd_o(csr_rd_o), .csr_addr_o(csr_addr_o),
    .csr_wr_data_o(csr_wr_data_o), .csr_be_o(csr_be_o),
    .csr_wait_rq_i(csr_wait_rq_i), .csr_rd_data_i(csr_rd_data_i),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic        write;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          stall;      // edges with wait_rq high before it drops
    logic [31:0] rd_val;     // responder data, one cycle after acceptance
    int          bp;         // cycles rsp_ready held low
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_strobe; // cycles the strobe is high
    int          exp_lat;    // edges from accept edge to first edge seeing rsp_valid
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_cmd_ready"}, 32'(cmd_ready_o), 32'd1);
    check({tag, "_rsp_valid"}, 32'(rsp_valid_o), 32'd0);
    check({tag, "_strobes"}, {30'd0, csr_wr_o, csr_rd_o}, 32'd0);
    check({tag, "_addr"}, 32'(csr_addr_o), 32'd0);
    check({tag, "_wdata"}, csr_wr_data_o, 32'd0);
    check({tag, "_be"}, 32'(csr_be_o), 32'd0);
    check({tag, "_rdata"}, rsp_rdata_o, 32'd0);
    check({tag, "_rsp_flags"}, {30'd0, rsp_write_o, rsp_error_o}, 32'd0);
  endtask

  task automatic check_rsp(input vec_t v, input string tag);
    check({tag, "_rsp_valid"}, 32'(rsp_valid_o), 32'd1);
    check({tag, "_rsp_rdata"}, rsp_rdata_o, v.exp_rdata);
    check({tag, "_rsp_write"}, 32'(rsp_write_o), 32'(v.write));
    check({tag, "_rsp_error"}, 32'(rsp_error_o), 32'(v.exp_err));
    check({tag, "_cmd_ready_busy"}, 32'(cmd_ready_o), 32'd0);
  endtask

  // driver: one command through strobe phase, response back-pressure and handshake
  task automatic run_vec(input vec_t v, input int idx);
    int    edges = 0;
    int    strobes = 0;
    bit    accepted_prev = 0;
    bit    done = 0;
    string tag = $sformatf("v%0d", idx);
    check({tag, "_cmd_ready_idle"}, 32'(cmd_ready_o), 32'd1);
    cmd_valid_i = 1'b1;
    cmd_write_i = v.write;
    cmd_addr_i  = v.addr;
    cmd_wdata_i = v.wdata;
    cmd_be_i    = v.be;
    csr_rd_data_i = JUNK;
    @(posedge clk);          // accept edge
    @(negedge clk);
    cmd_valid_i = 1'b0;
    cmd_wdata_i = 32'h0;
    for (int k = 0; k < 100; k++) begin
      if (rsp_valid_o) begin
        done = 1;
        break;
      end
      csr_rd_data_i = accepted_prev ? v.rd_val : JUNK;
      if (csr_wr_o || csr_rd_o) begin
        strobes++;
        check({tag, "_wr"}, 32'(csr_wr_o), 32'(v.write));
        check({tag, "_rd"}, 32'(csr_rd_o), 32'(!v.write));
        check({tag, "_addr"}, 32'(csr_addr_o), 32'(v.addr));
        check({tag, "_wdata"}, csr_wr_data_o, v.wdata);
        check({tag, "_be"}, 32'(csr_be_o), 32'(v.be));
      end
      csr_wait_rq_i = (edges < v.stall);
      accepted_prev = (csr_wr_o || csr_rd_o) && !csr_wait_rq_i;
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    csr_wait_rq_i = 1'b0;
    csr_rd_data_i = JUNK;
    if (!done) check({tag, "_rsp_never_valid"}, 32'd0, 32'd1);
    check({tag, "_latency"}, 32'(edges + 1), 32'(v.exp_lat));
    check({tag, "_strobe_cycles"}, 32'(strobes), 32'(v.exp_strobe));
    check_rsp(v, tag);
    for (int b = 0; b < v.bp; b++) begin
      @(posedge clk);
      @(negedge clk);
      check_rsp(v, {tag, "_bp"});
    end
    rsp_ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready_i = 1'b0;
    check({tag, "_rsp_cleared"}, 32'(rsp_valid_o), 32'd0);
    check({tag, "_cmd_ready_after"}, 32'(cmd_ready_o), 32'd1);
  endtask

  initial begin
    //             wr    addr   wdata          be    stall rd_val        bp exp_rdata      err strobe lat
    vecs[0] = '{1'b1, 4'h0, 32'hDEADBEEF, 4'hF, 0,   JUNK,         0, 32'h0,         1'b0, 1,  2};
    vecs[1] = '{1'b1, 4'h0, 32'hDEADBEEF, 4'hF, 3,   JUNK,         0, 32'h0,         1'b0, 4,  5};
    vecs[2] = '{1'b0, 4'h8, 32'h0,        4'hF, 0,   32'h00001234, 0, 32'h00001234,  1'b0, 1,  3};
    vecs[3] = '{1'b0, 4'h4, 32'h11112222, 4'h3, 2,   32'hCAFEF00D, 0, 32'hCAFEF00D,  1'b0, 3,  5};
    vecs[4] = '{1'b0, 4'h4, 32'h0,        4'hF, 30,  32'h12345678, 0, 32'h0,         1'b1, 16, 17};
    vecs[5] = '{1'b1, 4'hC, 32'h5555AAAA, 4'h5, 0,   JUNK,         5, 32'h0,         1'b0, 1,  2};
    vecs[6] = '{1'b0, 4'hC, 32'h0,        4'hF, 1,   32'h0BADF00D, 5, 32'h0BADF00D,  1'b0, 2,  4};
    vecs[7] = '{1'b1, 4'h8, 32'h00C0FFEE, 4'hF, 15,  JUNK,         0, 32'h0,         1'b0, 16, 17};
    vecs[8] = '{1'b1, 4'h8, 32'h00C0FFEE, 4'hF, 16,  JUNK,         0, 32'h0,         1'b1, 16, 17};

    reset = 1'b1;
    cmd_valid_i = 1'b0; cmd_write_i = 1'b0; cmd_addr_i = 4'h0;
    cmd_wdata_i = 32'h0; cmd_be_i = 4'h0;
    rsp_ready_i = 1'b0; csr_wait_rq_i = 1'b0; csr_rd_data_i = JUNK;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // reset while a read is stalled in REQ: aborted, no response afterwards
    cmd_valid_i = 1'b1; cmd_write_i = 1'b0; cmd_addr_i = 4'h8;
    cmd_be_i = 4'hF; csr_wait_rq_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid_i = 1'b0;
    check("rst_req_rd_strobe", 32'(csr_rd_o), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    csr_wait_rq_i = 1'b0;
    check_idle_outputs("rst_req");
    rsp_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_req_no_rsp", 32'(rsp_valid_o), 32'd0);
    end
    rsp_ready_i = 1'b0;

    // bridge still usable after the abort
    run_vec(vecs[2], 20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
